// File: rtl/x_sff_pkg.sv
// Shared types and elaboration helpers for the X_SFF control sequencer.
package x_sff_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        READY  = 2'd1,
        LOAD   = 2'd2,
        PRESET = 2'd3
    } x_sff_seq_state_t;

    function automatic bit x_sff_params_ok(input int init_cycles, input int load_len);
        return (init_cycles >= 1) && (load_len >= 1);
    endfunction

endpackage

// File: rtl/x_sff_down_cnt.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module x_sff_down_cnt #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/x_sff_ctrl_seq.sv
// Sequencer driving CE/SRST/SSET of an X_SFF flop bank: timed clear, load windows, preset pulses.
// state  | meaning
// INIT   | SRST held while the counter runs down
// READY  | idle, requests sampled (CLR > SET > LOAD)
// LOAD   | CE window, paused by HOLD
// PRESET | single SSET cycle
module x_sff_ctrl_seq
    import x_sff_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int LOAD_LEN    = 8,
    parameter int CNT_W       = $clog2(((INIT_CYCLES > LOAD_LEN) ? INIT_CYCLES : LOAD_LEN) + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic LOAD_REQ,
    input  logic HOLD,
    input  logic SET_REQ,
    input  logic CLR_REQ,
    output logic CE,
    output logic SRST,
    output logic SSET,
    output logic BUSY,
    output logic DONE
);

    if (!x_sff_params_ok(INIT_CYCLES, LOAD_LEN)) begin : g_param_err
        $error("x_sff_ctrl_seq: INIT_CYCLES and LOAD_LEN must both be >= 1");
    end

    localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LD = CNT_W'(LOAD_LEN - 1);

    x_sff_seq_state_t state_q, state_d;
    logic ce_q, ce_d, srst_q, srst_d, sset_q, sset_d, busy_q, busy_d, done_q, done_d;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    x_sff_down_cnt #(
        .W       (CNT_W),
        .RST_VAL (INIT_LD)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        ce_d     = 1'b0;
        srst_d   = 1'b0;
        sset_d   = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = INIT_LD;

        unique case (state_q)
            INIT: begin
                if (cnt_zero) begin
                    state_d = READY;
                end else begin
                    srst_d = 1'b1;
                    cnt_en = 1'b1;
                end
            end
            READY: begin
                if (CLR_REQ) begin
                    state_d  = INIT;
                    srst_d   = 1'b1;
                    cnt_load = 1'b1;
                end else if (SET_REQ) begin
                    state_d = PRESET;
                    sset_d  = 1'b1;
                end else if (LOAD_REQ) begin
                    state_d  = LOAD;
                    ce_d     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = LOAD_LD;
                end
            end
            PRESET: begin
                state_d = READY;
                if (CLR_REQ) begin
                    state_d  = INIT;
                    srst_d   = 1'b1;
                    cnt_load = 1'b1;
                end
            end
            LOAD: begin
                if (CLR_REQ) begin
                    state_d  = INIT;
                    srst_d   = 1'b1;
                    cnt_load = 1'b1;
                end else if (ce_q && cnt_zero) begin
                    state_d = READY;
                    done_d  = 1'b1;
                end else begin
                    // Counter only advances on cycles that actually enabled the bank.
                    cnt_en = ce_q;
                    ce_d   = !HOLD;
                end
            end
        endcase

        busy_d = (state_d != READY);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= INIT;
            ce_q    <= 1'b0;
            srst_q  <= 1'b1;
            sset_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            srst_q  <= srst_d;
            sset_q  <= sset_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign CE   = ce_q;
    assign SRST = srst_q;
    assign SSET = sset_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_x_sff_ctrl_seq.sv
// Scoreboard bench for x_sff_ctrl_seq: expected output vectors {CE,SRST,SSET,BUSY,DONE} per cycle.
module tb_x_sff_ctrl_seq;

    localparam int INIT_CYCLES = 4;
    localparam int LOAD_LEN    = 8;

    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_SRST = 5'b01010;
    localparam logic [4:0] O_SSET = 5'b00110;
    localparam logic [4:0] O_CE   = 5'b10010;
    localparam logic [4:0] O_HOLD = 5'b00010;
    localparam logic [4:0] O_DONE = 5'b00001;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic LOAD_REQ = 1'b0, HOLD = 1'b0, SET_REQ = 1'b0, CLR_REQ = 1'b0;
    logic CE, SRST, SSET, BUSY, DONE;
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic [4:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    x_sff_ctrl_seq #(
        .INIT_CYCLES (INIT_CYCLES),
        .LOAD_LEN    (LOAD_LEN)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD_REQ (LOAD_REQ),
        .HOLD     (HOLD),
        .SET_REQ  (SET_REQ),
        .CLR_REQ  (CLR_REQ),
        .CE       (CE),
        .SRST     (SRST),
        .SSET     (SSET),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;
    assign obs = {CE, SRST, SSET, BUSY, DONE};

    task automatic test_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if (obs !== O_SRST) begin
            n_bad++; $display("FAIL reset_held: got %b want %b", obs, O_SRST);
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (obs !== O_SRST) begin
            n_bad++; $display("FAIL reset_release: got %b want %b", obs, O_SRST);
        end
        for (int i = 0; i < INIT_CYCLES - 1; i++) exp_q.push_back(O_SRST);
        exp_q.push_back(O_IDLE);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            {LOAD_REQ, HOLD, SET_REQ, CLR_REQ} = 4'b0000;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL reset_seq cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < LOAD_LEN; i++) exp_q.push_back(O_CE);
        exp_q.push_back(O_DONE);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            LOAD_REQ = (i == 0); HOLD = 1'b0; SET_REQ = 1'b0; CLR_REQ = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL load cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_hold(input int hstart, input int hlen);
        for (int i = 0; i < hstart; i++) exp_q.push_back(O_CE);
        for (int i = 0; i < hlen; i++) exp_q.push_back(O_HOLD);
        for (int i = 0; i < LOAD_LEN - hstart; i++) exp_q.push_back(O_CE);
        exp_q.push_back(O_DONE);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            LOAD_REQ = (i == 0);
            HOLD     = (i >= hstart) && (i < hstart + hlen);
            SET_REQ  = (i == hstart + 1);
            CLR_REQ  = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL hold_%0d_%0d cyc%0d: got %b want %b", hstart, hlen, i, obs, exp_v);
            end
        end
    endtask

    task automatic test_set_priority();
        exp_q.push_back(O_SSET);
        exp_q.push_back(O_IDLE);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            LOAD_REQ = (i == 0); SET_REQ = (i == 0); HOLD = 1'b0; CLR_REQ = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL set_prio cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_set_back_to_back();
        exp_q.push_back(O_SSET);
        exp_q.push_back(O_IDLE);
        exp_q.push_back(O_SSET);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            SET_REQ = (i < 3); LOAD_REQ = 1'b0; HOLD = 1'b0; CLR_REQ = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL set_b2b cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_clr_in_load();
        for (int i = 0; i < 5; i++) exp_q.push_back(O_CE);
        for (int i = 0; i < INIT_CYCLES; i++) exp_q.push_back(O_SRST);
        exp_q.push_back(O_IDLE);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            LOAD_REQ = (i == 0); CLR_REQ = (i == 5); HOLD = 1'b0; SET_REQ = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL clr_load cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_clr_in_preset();
        exp_q.push_back(O_SSET);
        for (int i = 0; i < INIT_CYCLES; i++) exp_q.push_back(O_SRST);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            SET_REQ = (i == 0); CLR_REQ = (i == 1); LOAD_REQ = 1'b0; HOLD = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL clr_preset cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < LOAD_LEN; i++) exp_q.push_back(O_CE);
            exp_q.push_back(O_DONE);
        end
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            LOAD_REQ = (i <= 2 * LOAD_LEN); HOLD = 1'b0; SET_REQ = 1'b0; CLR_REQ = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(O_CE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            LOAD_REQ = (i == 0); HOLD = 1'b0; SET_REQ = 1'b0; CLR_REQ = 1'b0;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL arst_pre cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
        #1;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_SRST) begin
            n_bad++; $display("FAIL arst_async: got %b want %b", obs, O_SRST);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < INIT_CYCLES - 1; i++) exp_q.push_back(O_SRST);
        exp_q.push_back(O_IDLE);
        exp_q.push_back(O_IDLE);
        for (int i = 0; exp_q.size() > 0; i++) begin
            {LOAD_REQ, HOLD, SET_REQ, CLR_REQ} = 4'b0000;
            @(posedge CLK); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL arst_init cyc%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_hold(3, 3);
        test_hold(1, 20);
        test_set_priority();
        test_set_back_to_back();
        test_clr_in_load();
        test_clr_in_preset();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
